// File: rtl/mem_access_unit.sv
// Initiator-side DataMemory access unit: byte/halfword/word loads and stores with read-modify-write for sub-word stores.
// Optional statistics counters are enabled by defining MEM_ACCESS_STATS_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] load_count,
  output logic [STAT_WIDTH-1:0] store_count,
  output logic [STAT_WIDTH-1:0] error_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic                  write_q, write_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic                  req_bad;
  logic [3:0]            lane_sel;
  logic [31:0]           store_repl;
  logic [31:0]           merged_word;
  logic [7:0]            byte_lane [4];
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [31:0]           load_ext;

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Store data is replicated across the word so each selected lane just picks its own slice.
  always_comb begin
    lane_sel   = 4'b1111;
    store_repl = data_q;
    case (size_q)
      SZ_BYTE: begin
        lane_sel   = 4'b0001 << addr_q[1:0];
        store_repl = {4{data_q[7:0]}};
      end
      SZ_HALF: begin
        lane_sel   = addr_q[1] ? 4'b1100 : 4'b0011;
        store_repl = {2{data_q[15:0]}};
      end
      default: begin
        lane_sel   = 4'b1111;
        store_repl = data_q;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi]          = mem_read_data[8*gi +: 8];
      assign merged_word[8*gi +: 8] = lane_sel[gi] ? store_repl[8*gi +: 8]
                                                   : mem_read_data[8*gi +: 8];
    end
  endgenerate

  assign load_byte = byte_lane[addr_q[1:0]];
  assign load_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

  always_comb begin
    load_ext = mem_read_data;
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_ext = {{16{signed_q & load_half[15]}}, load_half};
      default: load_ext = mem_read_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          data_d   = req_wdata;
          rdata_d  = 32'd0;
          error_d  = req_bad;
          if (req_bad) begin
            state_d = ST_RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (write_q) begin
          data_d  = merged_word;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      data_q   <= 32'd0;
      rdata_q  <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // All handshake and memory strobes decode straight from the state register.
  assign req_ready      = (state_q == ST_IDLE);
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_error     = (state_q == ST_RESP) & error_q;
  assign resp_rdata     = rdata_q;
  assign mem_write      = (state_q == ST_WRITE);
  assign mem_address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_write_data = data_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [STAT_WIDTH-1:0] load_cnt_q, load_cnt_d;
  logic [STAT_WIDTH-1:0] store_cnt_q, store_cnt_d;
  logic [STAT_WIDTH-1:0] error_cnt_q, error_cnt_d;

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    error_cnt_d = error_cnt_q;
    if (state_q == ST_RESP) begin
      if (error_q) begin
        if (error_cnt_q != '1) error_cnt_d = error_cnt_q + 1'b1;
      end else if (write_q) begin
        if (store_cnt_q != '1) store_cnt_d = store_cnt_q + 1'b1;
      end else begin
        if (load_cnt_q != '1) load_cnt_d = load_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      error_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      error_cnt_q <= error_cnt_d;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
  assign error_count = error_cnt_q;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the DataMemory port (clk, MemWrite, address, write_data, read_data); sits between the MEM pipeline stage and DataMemory.
- Accepts byte/halfword/word load and store requests over a valid/ready handshake and turns each into word-aligned DataMemory accesses.
- Sub-word stores use read-modify-write; loads are returned sign- or zero-extended.
- Only one request may be outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_address.
- STAT_WIDTH, 16, width of the statistics counters (only used with MEM_ACCESS_STATS_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; logic is in reset while reset=0.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
- req_signed  in  1  sign-extend load data; ignored for stores.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request, qualified by resp_valid.
- mem_write  out  1  to DataMemory MemWrite.
- mem_address  out  ADDR_WIDTH  to DataMemory address; always {addr[ADDR_WIDTH-1:2],2'b00}.
- mem_write_data  out  32  to DataMemory write_data.
- mem_read_data  in  32  from DataMemory read_data; combinational read, write commits on the rising clk edge.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - mem_write=0, resp_valid=0, resp_error=0, resp_rdata=0.
  - Latched addr, size, signed, write and data registers clear to 0, so mem_address=0 and mem_write_data=0.
- Acceptance: a request is accepted in a cycle where req_valid & req_ready; all request fields are latched at that edge. req_ready=0 in every other state.
- States IDLE, READ, WRITE, RESP. Transitions from IDLE on accept:
  - Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or size=11 goes to RESP with error. DataMemory is never accessed.
  - Any load goes to READ.
  - Word store goes to WRITE with merged = req_wdata.
  - Byte or halfword store goes to READ (read-modify-write).
- READ:
  - mem_write=0; mem_read_data is captured at the edge.
  - Load: goes to RESP.
  - Store: goes to WRITE with merged = captured word with the target lanes replaced.
- WRITE: mem_write=1, mem_write_data=merged, then goes to RESP. The memory commits at the exiting edge.
- RESP: resp_valid=1 for exactly one cycle, then goes to IDLE.
- Outputs: mem_write is decoded from the state register only (high only in WRITE), so it is glitch-free.
- Lanes (little-endian):
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Load extension: the extracted lane is sign-extended if req_signed=1, otherwise zero-extended to 32 bits.
- Latency, counted from accept cycle N (resp_valid cycle):
  - Error: N+1.
  - Load: N+2.
  - Word store: N+2.
  - Sub-word store: N+3.
- Next accept: earliest in the cycle after resp_valid. A req_valid held high in the meantime simply waits.
- Reset during WRITE: mem_write drops immediately, so no commit occurs at the following edge. No resp_valid is generated for the aborted request.
- Address wrap: none. Only addr[1:0] is interpreted; upper bits pass through unchanged.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- When defined:
  - Adds outputs load_count, store_count and error_count, each STAT_WIDTH wide.
  - Each counter increments in the RESP cycle of the matching completion; errors count only in error_count.
  - Counters saturate at all-ones and clear on reset.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
1. Word store addr 0x4 data 0x11111111, then word load 0x4:
   - mem_write high exactly one cycle with mem_address=0x4.
   - Load resp_rdata=0x11111111 at N+2, resp_error=0.
2. Memory word at 0x8 = 0x22222222; byte store 0xAB to 0x9:
   - READ then WRITE, with mem_write_data=0x2222AB22 and resp_valid at N+3.
   - Word load 0x8 then returns 0x2222AB22.
3. After scenario 2, three loads:
   - Signed byte load 0x9 returns 0xFFFFFFAB.
   - Unsigned byte load 0x9 returns 0x000000AB.
   - Signed halfword load 0xA returns 0x00002222.
4. Word load 0x6, then halfword store 0x3:
   - Each gives resp_valid at N+1 with resp_error=1 and resp_rdata=0.
   - mem_write stays 0 throughout.
5. Word store 0x8 data 0x33333333 with reset driven low in the WRITE cycle:
   - mem_write falls combinationally, state is IDLE, no resp_valid.
   - A later load of 0x8 returns 0x2222AB22.
6. req_valid held high for two back-to-back word loads:
   - req_ready=0 for N+1..N+2; second request accepted at N+3.
   - With MEM_ACCESS_STATS_EN defined, load_count=2 afterwards.
